pc_fetch: RTL and testbench

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/br_pkg.sv | 28 ++
 rtl/pc_fetch_if.sv | 20 ++
 rtl/pc_target.sv | 36 +++
 rtl/pc_fetch.sv | 146 ++++++++++++++
 tb/tb_pc_fetch.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg
// Shared definitions for the fetch / branch-resolution slice:
//   - bruop_e        : encodings of the resolving instruction's branch op
//   - fetchState_e   : states of the pc_fetch controller
//   - RESET_PC_DEFAULT : default first fetch address after reset
// ---------------------------------------------------------------------------
package br_pkg;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_LT   = 3'd2,
    BR_GE   = 3'd3,
    BR_JAL  = 3'd4,
    BR_JALR = 3'd5,
    BR_OFF  = 3'd7
  } bruop_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_TRAP = 2'd2
  } fetchState_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_if
// Instruction-memory handshake between the fetch unit and instruction memory.
//   req   : fetch request (fetch -> memory)
//   addr  : fetch address (fetch -> memory)
//   ack   : request accepted, rdata valid in the same cycle (memory -> fetch)
//   rdata : instruction word (memory -> fetch)
// Modports: master = fetch side, slave = memory side.
// ---------------------------------------------------------------------------
interface pc_fetch_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pc_target.sv
// ---------------------------------------------------------------------------
// pc_target
// Purely combinational redirect-target computation.
//   i_bruop    : op of the resolving instruction (JALR selects the rs1 base)
//   i_brPc     : PC of the resolving instruction
//   i_imm      : sign-extended offset
//   i_rs1      : rs1 value used by JALR
//   o_target   : redirect target address
//   o_misalign : target is not 4-byte aligned (bit 1 set)
// ---------------------------------------------------------------------------
module pc_target
  import br_pkg::*;
(
  input  logic [2:0]  i_bruop,
  input  logic [31:0] i_brPc,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_rs1,
  output logic [31:0] o_target,
  output logic        o_misalign
);

  logic [31:0] w_base;
  logic [31:0] w_sum;

  // JALR adds to rs1 and drops bit 0; all other ops are PC-relative.
  always_comb begin
    w_base   = (i_bruop == BR_JALR) ? i_rs1 : i_brPc;
    w_sum    = w_base + i_imm;
    o_target = (i_bruop == BR_JALR) ? (w_sum & ~32'h1) : w_sum;
  end

  // Bit 0 is either cleared (JALR) or irrelevant to word fetch; bit 1 is
  // what makes a target unfetchable.
  assign o_misalign = o_target[1];

endmodule

// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
// Program counter plus a one-entry fetch buffer with branch redirect.
//   RESET_PC       : first fetch address after reset
//   clk, rst       : clock, asynchronous active-high reset
//   doBranch       : branch taken (qualified by br_valid)
//   br_valid       : branch/jump resolution valid this cycle
//   BRUOP          : op of the resolving instruction
//   br_pc, imm, rs1: operands for the redirect target
//   stall          : downstream not consuming; buffer holds
//   imem           : instruction-memory handshake (master side)
//   if_valid/if_instr/if_pc : fetch buffer contents
//   flush          : combinational, high in a redirect cycle
//   misalign       : sticky, set on a misaligned redirect target
// ---------------------------------------------------------------------------
module pc_fetch
  import br_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        doBranch,
  input  logic        br_valid,
  input  logic [2:0]  BRUOP,
  input  logic [31:0] br_pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        stall,
  pc_fetch_if.master  imem,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        misalign
);

  fetchState_e r_state;
  fetchState_e w_stateNext;

  logic [31:0] r_pc;
  logic        r_ifValid;
  logic [31:0] r_ifInstr;
  logic [31:0] r_ifPc;
  logic        r_misalign;

  logic [31:0] w_target;
  logic        w_tgtMisalign;
  logic        w_redirect;
  logic        w_req;
  logic        w_accept;

  pc_target u_pcTarget (
    .i_bruop   (BRUOP),
    .i_brPc    (br_pc),
    .i_imm     (imm),
    .i_rs1     (rs1),
    .o_target  (w_target),
    .o_misalign(w_tgtMisalign)
  );

  // Once trapped, further resolutions are ignored until reset.
  assign w_redirect = br_valid && doBranch && (r_state != ST_TRAP);
  assign w_accept   = w_req && imem.ack && !w_redirect;

  // State register for the fetch controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and request logic. The request is gated by rst so that it
  // drops immediately when reset is asserted mid-request. Redirect overrides
  // every other transition.
  always_comb begin
    w_stateNext = r_state;
    w_req       = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_RUN: begin
          w_req = !(r_ifValid && stall);
          if (w_req && imem.ack && stall) begin
            w_stateNext = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_stateNext = ST_RUN;
          end
        end
        ST_TRAP: begin
          w_stateNext = ST_TRAP;
        end
        default: begin
          w_stateNext = ST_RUN;
        end
      endcase
      if (w_redirect) begin
        w_stateNext = w_tgtMisalign ? ST_TRAP : ST_RUN;
      end
    end
  end

  // PC and fetch buffer. A redirect squashes the buffer and discards any
  // same-cycle ack; an accept may overwrite a draining buffer so back-to-back
  // fetches run without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_ifValid  <= 1'b0;
      r_ifInstr  <= 32'h0;
      r_ifPc     <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_ifValid <= 1'b0;
        if (w_tgtMisalign) begin
          r_misalign <= 1'b1;
        end else begin
          r_pc <= w_target;
        end
      end else if (r_state == ST_TRAP) begin
        r_ifValid <= 1'b0;
      end else if (w_accept) begin
        r_ifInstr <= imem.rdata;
        r_ifPc    <= r_pc;
        r_ifValid <= 1'b1;
        r_pc      <= r_pc + 32'd4;
      end else if (r_ifValid && !stall) begin
        r_ifValid <= 1'b0;
      end
    end
  end

  assign imem.req  = w_req;
  assign imem.addr = r_pc;
  assign if_valid  = r_ifValid;
  assign if_instr  = r_ifInstr;
  assign if_pc     = r_ifPc;
  assign flush     = w_redirect;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch
// Directed, self-checking bench for pc_fetch. The memory model returns
// addr ^ 32'hDEAD_0000 with a bench-controlled ack.
// ---------------------------------------------------------------------------
module tb_pc_fetch;
  import br_pkg::*;

  localparam logic [31:0] MEM_KEY = 32'hDEAD_0000;

  logic        clk;
  logic        rst;
  logic        doBranch;
  logic        br_valid;
  logic [2:0]  BRUOP;
  logic [31:0] br_pc;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        misalign;

  int nVectors;
  int nMiscompares;

  pc_fetch_if u_if ();

  assign u_if.rdata = u_if.addr ^ MEM_KEY;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk     (clk),
    .rst     (rst),
    .doBranch(doBranch),
    .br_valid(br_valid),
    .BRUOP   (BRUOP),
    .br_pc   (br_pc),
    .imm     (imm),
    .rs1     (rs1),
    .stall   (stall),
    .imem    (u_if),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc   (if_pc),
    .flush   (flush),
    .misalign(misalign)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    nVectors++; if (u_if.addr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rst_addr got %h exp %h", u_if.addr, 32'h0); end
    nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_req got %b exp 0", u_if.req); end
    nVectors++; if (if_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_valid got %b exp 0", if_valid); end
    nVectors++; if (misalign !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_misalign got %b exp 0", misalign); end
    nVectors++; if (if_instr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rst_instr got %h exp 0", if_instr); end
    nVectors++; if (if_pc !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rst_ifpc got %h exp 0", if_pc); end
    nVectors++; if (flush !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst_flush got %b exp 0", flush); end
  endtask

  task automatic test_sequential();
    u_if.ack = 1'b1;
    rst = 1'b0;
    #1;
    nVectors++; if (u_if.addr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL seq_addr0 got %h exp 0", u_if.addr); end
    nVectors++; if (u_if.req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL seq_req0 got %b exp 1", u_if.req); end
    for (int i = 1; i <= 3; i++) begin
      logic [31:0] expAddr;
      logic [31:0] expPc;
      expAddr = 32'(4 * i);
      expPc   = 32'(4 * (i - 1));
      tick();
      nVectors++; if (u_if.addr !== expAddr) begin nMiscompares++; $display("[TB] FAIL seq_addr%0d got %h exp %h", i, u_if.addr, expAddr); end
      nVectors++; if (if_pc !== expPc) begin nMiscompares++; $display("[TB] FAIL seq_ifpc%0d got %h exp %h", i, if_pc, expPc); end
      nVectors++; if (if_instr !== (expPc ^ MEM_KEY)) begin nMiscompares++; $display("[TB] FAIL seq_instr%0d got %h exp %h", i, if_instr, expPc ^ MEM_KEY); end
      nVectors++; if (if_valid !== 1'b1) begin nMiscompares++; $display("[TB] FAIL seq_valid%0d got %b exp 1", i, if_valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL stall_req got %b exp 0", u_if.req); end
    for (int i = 0; i < 3; i++) begin
      tick();
      nVectors++; if (if_pc !== 32'h8) begin nMiscompares++; $display("[TB] FAIL stall_ifpc%0d got %h exp 8", i, if_pc); end
      nVectors++; if (if_instr !== (32'h8 ^ MEM_KEY)) begin nMiscompares++; $display("[TB] FAIL stall_instr%0d got %h exp %h", i, if_instr, 32'h8 ^ MEM_KEY); end
      nVectors++; if (u_if.addr !== 32'hC) begin nMiscompares++; $display("[TB] FAIL stall_addr%0d got %h exp c", i, u_if.addr); end
      nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL stall_req%0d got %b exp 0", i, u_if.req); end
    end
    stall = 1'b0;
    #1;
    nVectors++; if (u_if.req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL unstall_req got %b exp 1", u_if.req); end
    tick();
    nVectors++; if (if_pc !== 32'hC) begin nMiscompares++; $display("[TB] FAIL unstall_ifpc got %h exp c", if_pc); end
    nVectors++; if (u_if.addr !== 32'h10) begin nMiscompares++; $display("[TB] FAIL unstall_addr got %h exp 10", u_if.addr); end
  endtask

  task automatic test_branch();
    br_valid = 1'b1;
    doBranch = 1'b1;
    BRUOP    = BR_EQ;
    br_pc    = 32'h40;
    imm      = 32'hFFFF_FFF8;
    #1;
    nVectors++; if (flush !== 1'b1) begin nMiscompares++; $display("[TB] FAIL br_flush got %b exp 1", flush); end
    tick();
    nVectors++; if (u_if.addr !== 32'h38) begin nMiscompares++; $display("[TB] FAIL br_addr got %h exp 38", u_if.addr); end
    nVectors++; if (if_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL br_valid got %b exp 0", if_valid); end
    nVectors++; if (if_pc !== 32'hC) begin nMiscompares++; $display("[TB] FAIL br_dropack got %h exp c", if_pc); end
    br_valid = 1'b0;
    doBranch = 1'b0;
    #1;
    nVectors++; if (flush !== 1'b0) begin nMiscompares++; $display("[TB] FAIL br_flush_off got %b exp 0", flush); end
  endtask

  task automatic test_hold();
    stall = 1'b1;
    #1;
    nVectors++; if (u_if.req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL hold_req_empty got %b exp 1", u_if.req); end
    tick();
    nVectors++; if (if_pc !== 32'h38) begin nMiscompares++; $display("[TB] FAIL hold_ifpc got %h exp 38", if_pc); end
    nVectors++; if (u_if.addr !== 32'h3C) begin nMiscompares++; $display("[TB] FAIL hold_addr got %h exp 3c", u_if.addr); end
    nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL hold_req got %b exp 0", u_if.req); end
    tick();
    nVectors++; if (if_pc !== 32'h38) begin nMiscompares++; $display("[TB] FAIL hold_ifpc2 got %h exp 38", if_pc); end
    stall = 1'b0;
    #1;
    nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL hold_exit_req got %b exp 0", u_if.req); end
    tick();
    nVectors++; if (if_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL hold_drain got %b exp 0", if_valid); end
    nVectors++; if (u_if.req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL hold_run_req got %b exp 1", u_if.req); end
    tick();
    nVectors++; if (if_pc !== 32'h3C) begin nMiscompares++; $display("[TB] FAIL hold_resume_ifpc got %h exp 3c", if_pc); end
    nVectors++; if (u_if.addr !== 32'h40) begin nMiscompares++; $display("[TB] FAIL hold_resume_addr got %h exp 40", u_if.addr); end
  endtask

  task automatic test_not_taken();
    br_valid = 1'b1;
    doBranch = 1'b0;
    BRUOP    = BR_NE;
    br_pc    = 32'h100;
    imm      = 32'h20;
    #1;
    nVectors++; if (flush !== 1'b0) begin nMiscompares++; $display("[TB] FAIL nt_flush got %b exp 0", flush); end
    tick();
    nVectors++; if (u_if.addr !== 32'h44) begin nMiscompares++; $display("[TB] FAIL nt_addr got %h exp 44", u_if.addr); end
    nVectors++; if (if_pc !== 32'h40) begin nMiscompares++; $display("[TB] FAIL nt_ifpc got %h exp 40", if_pc); end
    br_valid = 1'b0;
  endtask

  task automatic test_wrap();
    br_valid = 1'b1;
    doBranch = 1'b1;
    BRUOP    = BR_JAL;
    br_pc    = 32'hFFFF_FFF0;
    imm      = 32'hC;
    tick();
    nVectors++; if (u_if.addr !== 32'hFFFF_FFFC) begin nMiscompares++; $display("[TB] FAIL wrap_tgt got %h exp fffffffc", u_if.addr); end
    br_valid = 1'b0;
    doBranch = 1'b0;
    tick();
    nVectors++; if (u_if.addr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL wrap_addr got %h exp 0", u_if.addr); end
    nVectors++; if (if_pc !== 32'hFFFF_FFFC) begin nMiscompares++; $display("[TB] FAIL wrap_ifpc got %h exp fffffffc", if_pc); end
    nVectors++; if (if_instr !== (32'hFFFF_FFFC ^ MEM_KEY)) begin nMiscompares++; $display("[TB] FAIL wrap_instr got %h exp %h", if_instr, 32'hFFFF_FFFC ^ MEM_KEY); end
  endtask

  task automatic test_jalr();
    br_valid = 1'b1;
    doBranch = 1'b1;
    BRUOP    = BR_JALR;
    rs1      = 32'h101;
    imm      = 32'h10;
    br_pc    = 32'h0;
    tick();
    nVectors++; if (u_if.addr !== 32'h110) begin nMiscompares++; $display("[TB] FAIL jalr_addr got %h exp 110", u_if.addr); end
    nVectors++; if (misalign !== 1'b0) begin nMiscompares++; $display("[TB] FAIL jalr_misalign got %b exp 0", misalign); end
    rs1 = 32'h102;
    imm = 32'h0;
    tick();
    nVectors++; if (misalign !== 1'b1) begin nMiscompares++; $display("[TB] FAIL trap_misalign got %b exp 1", misalign); end
    nVectors++; if (u_if.addr !== 32'h110) begin nMiscompares++; $display("[TB] FAIL trap_addr got %h exp 110", u_if.addr); end
    nVectors++; if (if_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL trap_valid got %b exp 0", if_valid); end
    nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL trap_req got %b exp 0", u_if.req); end
    rs1 = 32'h200;
    #1;
    nVectors++; if (flush !== 1'b0) begin nMiscompares++; $display("[TB] FAIL trap_flush got %b exp 0", flush); end
    for (int i = 0; i < 2; i++) begin
      tick();
      nVectors++; if (u_if.addr !== 32'h110) begin nMiscompares++; $display("[TB] FAIL trap_hold_addr%0d got %h exp 110", i, u_if.addr); end
      nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL trap_hold_req%0d got %b exp 0", i, u_if.req); end
      nVectors++; if (misalign !== 1'b1) begin nMiscompares++; $display("[TB] FAIL trap_hold_mis%0d got %b exp 1", i, misalign); end
    end
    br_valid = 1'b0;
    doBranch = 1'b0;
  endtask

  task automatic test_reset_midreq();
    rst = 1'b1;
    #1;
    nVectors++; if (misalign !== 1'b0) begin nMiscompares++; $display("[TB] FAIL rst2_misalign got %b exp 0", misalign); end
    nVectors++; if (u_if.addr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL rst2_addr got %h exp 0", u_if.addr); end
    rst = 1'b0;
    u_if.ack = 1'b1;
    tick();
    tick();
    nVectors++; if (u_if.addr !== 32'h8) begin nMiscompares++; $display("[TB] FAIL mid_pre_addr got %h exp 8", u_if.addr); end
    u_if.ack = 1'b0;
    tick();
    nVectors++; if (u_if.req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL mid_req got %b exp 1", u_if.req); end
    nVectors++; if (if_valid !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mid_drain got %b exp 0", if_valid); end
    rst = 1'b1;
    #1;
    nVectors++; if (u_if.addr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL mid_rst_addr got %h exp 0", u_if.addr); end
    nVectors++; if (u_if.req !== 1'b0) begin nMiscompares++; $display("[TB] FAIL mid_rst_req got %b exp 0", u_if.req); end
    nVectors++; if (if_pc !== 32'h0) begin nMiscompares++; $display("[TB] FAIL mid_rst_ifpc got %h exp 0", if_pc); end
    nVectors++; if (if_instr !== 32'h0) begin nMiscompares++; $display("[TB] FAIL mid_rst_instr got %h exp 0", if_instr); end
    rst = 1'b0;
    u_if.ack = 1'b1;
    #1;
    nVectors++; if (u_if.req !== 1'b1) begin nMiscompares++; $display("[TB] FAIL post_rst_req got %b exp 1", u_if.req); end
    tick();
    nVectors++; if (if_pc !== 32'h0) begin nMiscompares++; $display("[TB] FAIL post_rst_ifpc got %h exp 0", if_pc); end
    nVectors++; if (u_if.addr !== 32'h4) begin nMiscompares++; $display("[TB] FAIL post_rst_addr got %h exp 4", u_if.addr); end
  endtask

  // Scenario sequence; each test starts where the previous one left off.
  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    rst          = 1'b1;
    doBranch     = 1'b0;
    br_valid     = 1'b0;
    BRUOP        = BR_OFF;
    br_pc        = 32'h0;
    imm          = 32'h0;
    rs1          = 32'h0;
    stall        = 1'b0;
    u_if.ack     = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_hold();
    test_not_taken();
    test_wrap();
    test_jalr();
    test_reset_midreq();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
